// File: rtl/fetch_frontend_pkg.sv
// Shared definitions for the instruction fetch front end: FSM state
// encoding, the default reset PC and the sequential PC step.
package fetch_frontend_pkg;

    typedef enum logic [1:0] {
        FETCH_RESET = 2'd0,  // one idle cycle after reset is released
        FETCH_RUN   = 2'd1,  // normal sequential fetch
        FETCH_DRAIN = 2'd2   // throwing away responses to pre-redirect requests
    } fetch_state_e;

    // First fetch address after reset.
    localparam logic [31:0] FETCH_RESET_PC = 32'h0100_0000;

    // Byte distance between consecutive sequential fetches.
    localparam int unsigned FETCH_PC_INCR = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO between instruction memory responses and decode.
// Write and read in the same cycle are both honoured, including when full.
// A flush empties it in one cycle and wins over a write in that cycle.
module fetch_fifo
    import fetch_frontend_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [1:0]       count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_wr;
    logic             do_rd;

    // Reads only pop a live entry; writes need a free slot or a pop in the same cycle.
    assign do_rd = rd_en_i && (count_q != 2'd0);
    assign do_wr = wr_en_i && ((count_q != 2'd2) || do_rd);

    // Capture payloads into the slot at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the count decides what is
        // valid, so clearing payload bits would only add reset fan-out. Non-blocking
        // assignments keep every register sampling pre-edge values, whatever the order.
        if (do_wr && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_rd) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_wr) - 2'(do_rd);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == 2'd0);

endmodule

// File: rtl/fetch_frontend.sv
// Instruction fetch front end: issues sequential fetch requests under a
// two-slot credit, pairs in-order responses with their PCs, buffers them in
// a 2-entry FIFO for decode, and handles redirects by flushing and draining
// responses that belong to the old path.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   -> misalign_o port exists; redirect targets are forced word aligned
//   undefined -> no misalign_o port; redirect targets are used as given
module fetch_frontend
    import fetch_frontend_pkg::*;
#(
    parameter int unsigned       DWIDTH   = 32,
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = AWIDTH'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              insn_valid_o,
    input  logic              insn_ready_i,
    output logic [DWIDTH-1:0] insn_o,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic [AWIDTH-1:0] pc_o
);

    localparam int unsigned EWIDTH = AWIDTH + DWIDTH;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] next_pc_q, next_pc_d;
    logic [1:0]        outstanding_q, outstanding_d;
    logic [1:0]        discard_q, discard_d;

    logic [1:0]        fifo_count;
    logic              fifo_empty;
    logic [EWIDTH-1:0] fifo_wr_data;
    logic [EWIDTH-1:0] fifo_rd_data;

    logic [2:0]        slots_in_use;
    logic              credit_ok;
    logic              req_fire;
    logic              dec_fire;
    logic              rsp_counted;
    logic              rsp_keep;
    logic [AWIDTH-1:0] rsp_pc;
    logic [AWIDTH-1:0] redirect_target;

    // ------------------------------------------------------------------
    // Redirect target shaping (optional alignment check)
    // ------------------------------------------------------------------
`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign redirect_target = {redirect_pc_i[AWIDTH-1:2], 2'b00};

    // One-cycle flag for a redirect whose target was not word aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign misalign_o = misalign_q;
`else
    assign redirect_target = redirect_pc_i;
`endif

    // ------------------------------------------------------------------
    // Handshakes and credit
    // ------------------------------------------------------------------
    // Every buffered or in-flight instruction holds one of the two FIFO
    // slots, so the FIFO can never be asked to accept more than it holds.
    assign slots_in_use = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok    = (slots_in_use < 3'd2);

    assign imem_req_valid_o = !rst && (state_q == FETCH_RUN) && !redirect_i && credit_ok;
    assign imem_addr_o      = next_pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign insn_valid_o = !rst && !fifo_empty;
    assign dec_fire     = insn_valid_o && insn_ready_i && !redirect_i;

    // Any response retires one outstanding request; a response with nothing
    // outstanding is a leftover from before reset and is ignored outright.
    assign rsp_counted = imem_rsp_valid_i && (outstanding_q != 2'd0);
    assign rsp_keep    = rsp_counted && (state_q == FETCH_RUN) && !redirect_i;

    // Requests in RUN are issued back to back from next_pc, so the oldest
    // outstanding one was issued outstanding_q steps behind it.
    assign rsp_pc = next_pc_q - (AWIDTH'(outstanding_q) * AWIDTH'(FETCH_PC_INCR));

    assign fifo_wr_data = {rsp_pc, imem_rsp_data_i};

    fetch_fifo #(
        .WIDTH (EWIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (redirect_i),
        .wr_en_i   (rsp_keep),
        .wr_data_i (fifo_wr_data),
        .rd_en_i   (dec_fire),
        .rd_data_o (fifo_rd_data),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty)
    );

    // Outputs read as zero whenever nothing is buffered.
    assign insn_o = insn_valid_o ? fifo_rd_data[DWIDTH-1:0]      : '0;
    assign pc_o   = insn_valid_o ? fifo_rd_data[EWIDTH-1:DWIDTH] : '0;

    // ------------------------------------------------------------------
    // FSM, PC and counter next-state
    // ------------------------------------------------------------------
    // Next-state for the fetch FSM, next_pc and the outstanding/discard counts.
    always_comb begin
        // NOTE: every _d is given its hold value first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d       = state_q;
        next_pc_d     = next_pc_q;
        outstanding_d = outstanding_q + 2'(req_fire) - 2'(rsp_counted);
        discard_d     = discard_q;

        case (state_q)
            FETCH_RESET: begin
                state_d = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (req_fire) begin
                    next_pc_d = next_pc_q + AWIDTH'(FETCH_PC_INCR);
                end
            end
            FETCH_DRAIN: begin
                discard_d = discard_q - 2'(rsp_counted);
                if (discard_d == 2'd0) begin
                    state_d = FETCH_RUN;
                end
            end
            default: begin
                state_d = FETCH_RESET;
            end
        endcase

        // A redirect overrides everything: requests still in flight become
        // discards, and a response landing this cycle is already one of them.
        if (redirect_i) begin
            next_pc_d     = redirect_target;
            discard_d     = outstanding_q - 2'(rsp_counted);
            outstanding_d = discard_d;
            state_d       = (discard_d != 2'd0) ? FETCH_DRAIN : FETCH_RUN;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH_RESET;
            next_pc_q     <= RESET_PC;
            outstanding_q <= 2'd0;
            discard_q     <= 2'd0;
        end else begin
            state_q       <= state_d;
            next_pc_q     <= next_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

endmodule

// File: doc/fetch_frontend.md
FETCH_FRONTEND -- requirements
Module: fetch_frontend

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DWIDTH, 32, instruction and data width.
- AWIDTH, 32, address width.
- RESET_PC, 32'h0100_0000, first fetch address.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock; rising edge.
- rst, in, 1, synchronous, active-high reset.
- imem_req_valid_o, out, 1, fetch request valid.
- imem_req_ready_i, in, 1, memory accepts request.
- imem_addr_o, out, AWIDTH, request address.
- imem_rsp_valid_i, in, 1, response valid; responses return in order, never back-pressured.
- imem_rsp_data_i, in, DWIDTH, instruction word.
- redirect_i, in, 1, taken branch or jump from execute.
- redirect_pc_i, in, AWIDTH, redirect target.
- insn_valid_o, out, 1, instruction available to decode.
- insn_ready_i, in, 1, decode consumes this cycle.
- insn_o, out, DWIDTH, instruction.
- pc_o, out, AWIDTH, PC of insn_o.

Function
REQ-003 A request handshake completes when imem_req_valid_o and imem_req_ready_i are both high; a decode handshake completes when insn_valid_o and insn_ready_i are both high.
REQ-004 The 2-entry FIFO holds {pc, insn}; insn_valid_o is high exactly when the FIFO is non-empty; insn_o and pc_o come from the head entry.
REQ-005 Credit rule: a request is issued only when occupancy plus outstanding count is less than 2; the outstanding count is 0..2.
REQ-006 next_pc increments by 4 on each request handshake and wraps modulo 2^AWIDTH.
REQ-007 FSM states:
- RESET: one cycle after rst deasserts, no request.
- RUN: normal fetch.
- DRAIN: discard stale responses.
REQ-008 RESET goes to RUN unconditionally.
REQ-009 In RUN, a response is written at the FIFO tail with the PC recorded when that request was issued; FIFO write and read in the same cycle are both honoured.
REQ-010 On redirect_i, in any state:
- flush the FIFO;
- set next_pc to redirect_pc_i;
- drop any decode handshake in that cycle;
- deassert imem_req_valid_o in that cycle;
- set the discard count to the outstanding count, not counting a response arriving that same cycle, which is itself discarded;
- enter DRAIN if the discard count is nonzero, else RUN.
REQ-011 In DRAIN:
- no requests are issued;
- each response decrements the discard count and is dropped;
- when the count reaches 0, go to RUN on the next cycle.
REQ-012 The first request after a redirect is issued no earlier than the cycle after the redirect and carries redirect_pc_i.
REQ-013 A full FIFO with no credit holds imem_req_valid_o low; the outputs stay stable while insn_ready_i is low.
REQ-014 imem_addr_o equals next_pc whenever imem_req_valid_o is high, and holds stable until the request handshake completes.

Reset
REQ-015 While rst is high:
- state is RESET;
- next_pc is RESET_PC;
- FIFO is empty;
- outstanding and discard counts are 0;
- imem_req_valid_o and insn_valid_o are 0;
- insn_o is 0 and pc_o is 0.
REQ-016 Reset mid-operation discards every in-flight response, and the first request issued after reset is RESET_PC.

Configuration
REQ-017 With FETCH_MISALIGN_CHECK_EN defined:
- add output misalign_o, 1 bit, registered;
- misalign_o pulses for one cycle when redirect_pc_i[1:0] is nonzero during a redirect;
- next_pc is forced to {redirect_pc_i[AWIDTH-1:2], 2'b00}.
REQ-018 Without FETCH_MISALIGN_CHECK_EN, the port is absent and the target is used unmodified.

Structure
REQ-019 The shared package holds the FSM state enum (FETCH_RESET, FETCH_RUN, FETCH_DRAIN), the RESET_PC default, and the PC increment constant 4.
REQ-020 The FIFO is the sub-module fetch_fifo (depth 2, width AWIDTH+DWIDTH, with flush), instantiated once.

Verification
REQ-021 Reset, memory always ready, 1-cycle latency, decode always ready -> request addresses are 0x01000000, 0x01000004, 0x01000008, and decode receives the matching pc/insn pairs in order.
REQ-022 insn_ready_i low for 10 cycles -> the FIFO fills to 2, imem_req_valid_o goes low, and no instruction is lost or duplicated.
REQ-023 Redirect to 0x01000100 with 2 requests outstanding -> 2 responses are dropped, DRAIN is visible, and the next insn_o has pc_o equal to 0x01000100.
REQ-024 Redirect in the same cycle as a response and a decode handshake -> the response is dropped, the FIFO ends empty, and the handshake is not counted.
REQ-025 With FETCH_MISALIGN_CHECK_EN, redirect to 0x01000102 -> misalign_o pulses once and the next request address is 0x01000100.
REQ-026 rst asserted with 2 outstanding requests -> the late responses are ignored and the first request after reset is 0x01000000.
